// File: rtl/alu_datapath_multi_pkg.sv
// alu_datapath_multi_pkg: opcode, operand-select, flag-index and FSM-state definitions
package alu_datapath_multi_pkg;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_ASR  = 4'h8;
  localparam logic [3:0] OP_ROL  = 4'h9;
  localparam logic [3:0] OP_ROR  = 4'hA;
  localparam logic [3:0] OP_PASS = 4'hB;
  localparam logic [3:0] OP_MUL  = 4'hC;
  localparam logic [3:0] OP_ADC  = 4'hD;
  localparam logic [3:0] OP_CMP  = 4'hE;
  localparam logic [1:0] CU_HOLD = 2'b00;
  localparam logic [1:0] CU_R    = 2'b01;
  localparam logic [1:0] CU_DMEM = 2'b10;
  localparam logic [1:0] CU_IR   = 2'b11;
  localparam int FZ = 3;
  localparam int FN = 2;
  localparam int FC = 1;
  localparam int FV = 0;
  typedef enum logic {ST_IDLE, ST_MUL} state_e;
endpackage

// File: rtl/alu_datapath_multi_alu_core.sv
// alu_core: single-cycle combinational ALU producing result, next flags and write enables
module alu_core
  import alu_datapath_multi_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic [3:0]       flags_i,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags_o,
  output logic             wr_r,
  output logic             wr_f
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           c;
  logic           v;
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADC) & flags_i[FC]};
    diff = {1'b0, a} - {1'b0, b};
    res  = a;
    c    = flags_i[FC];
    v    = 1'b0;
    wr_r = 1'b1;
    wr_f = 1'b1;
    case (op)
      OP_ADD, OP_ADC: begin
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        res  = diff[WIDTH-1:0];
        c    = ~diff[WIDTH];
        v    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        wr_r = (op == OP_SUB);
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOT:  res = ~a;
      OP_SHL: begin
        res = {a[WIDTH-2:0], 1'b0};
        c   = a[WIDTH-1];
      end
      OP_SHR: begin
        res = {1'b0, a[WIDTH-1:1]};
        c   = a[0];
      end
      OP_ASR: begin
        res = {a[WIDTH-1], a[WIDTH-1:1]};
        c   = a[0];
      end
      OP_ROL: begin
        res = {a[WIDTH-2:0], a[WIDTH-1]};
        c   = a[WIDTH-1];
      end
      OP_ROR: begin
        res = {a[0], a[WIDTH-1:1]};
        c   = a[0];
      end
      OP_PASS: res = b;
      default: begin
        wr_r = 1'b0;
        wr_f = 1'b0;
      end
    endcase
    flags_o     = '0;
    flags_o[FZ] = ~|res;
    flags_o[FN] = res[WIDTH-1];
    flags_o[FC] = c;
    flags_o[FV] = v;
  end
endmodule

// File: rtl/alu_datapath_multi.sv
// alu_datapath_multi: A/B/R register datapath around alu_core with a shift-add multi-cycle multiplier
module alu_datapath_multi
  import alu_datapath_multi_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             reset_alu_datapath_n,
  input  logic [WIDTH-1:0] dmem_data,
  input  logic [WIDTH-1:0] ir_operand,
  input  logic [1:0]       cu_A,
  input  logic [1:0]       cu_B,
  input  logic [3:0]       opcode,
  input  logic             RER,
  output logic [WIDTH-1:0] R,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, mplier_q, mplier_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, mul_sum;
  logic [WIDTH-1:0] core_res;
  logic [3:0]       core_flags;
  logic             core_wr_r, core_wr_f;
  alu_core #(.WIDTH(WIDTH)) u_core (
    .a       (a_q),
    .b       (b_q),
    .op      (opcode),
    .flags_i (flags_q),
    .res     (core_res),
    .flags_o (core_flags),
    .wr_r    (core_wr_r),
    .wr_f    (core_wr_f)
  );
  function automatic logic [WIDTH-1:0] pick(input logic [1:0] cu, input logic [WIDTH-1:0] cur);
    return cu == CU_R ? r_q : cu == CU_DMEM ? dmem_data : cu == CU_IR ? ir_operand : cur;
  endfunction
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    flags_d  = flags_q;
    state_d  = state_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    if (state_q == ST_IDLE) begin
      a_d = pick(cu_A, a_q);
      b_d = pick(cu_B, b_q);
      if (RER && opcode == OP_MUL && MUL_EN != 0) begin
        state_d  = ST_MUL;
        cnt_d    = '0;
        mcand_d  = {{WIDTH{1'b0}}, a_q};
        mplier_d = b_q;
        acc_d    = '0;
      end else if (RER) begin
        r_d     = core_wr_r ? core_res : r_q;
        flags_d = core_wr_f ? core_flags : flags_q;
        done_d  = 1'b1;
      end
    end else begin
      // one partial product per cycle; the last step writes back straight from the adder
      acc_d    = mul_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d     = ST_IDLE;
        r_d         = mul_sum[WIDTH-1:0];
        flags_d[FZ] = ~|mul_sum[WIDTH-1:0];
        flags_d[FN] = mul_sum[WIDTH-1];
        flags_d[FC] = |mul_sum[2*WIDTH-1:WIDTH];
        flags_d[FV] = |mul_sum[2*WIDTH-1:WIDTH];
        done_d      = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_alu_datapath_n) begin
    if (!reset_alu_datapath_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end
  assign R     = r_q;
  assign flags = flags_q;
  assign busy  = (state_q == ST_MUL);
  assign done  = done_q;
endmodule
